dram_arb: RTL and testbench

Two-port arbiter and sequencer for the hxd32 single-port data RAM. It shares the RAM between the core load/store path (port 0) and the debug/loader path (port 1). It generates byte enables, word addresses and lane-shifted store data, and routes read data back right-aligned so the writeback extender can sign- or zero-extend from bit 0. It sits between the execute-stage memory request and the RAM macro; the writeback stage consumes its response.

---
 rtl/dram_arb.sv | 147 ++++++++++++++
 tb/tb_dram_arb.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_arb.sv
// Two-port arbiter/sequencer for the hxd32 single-port data RAM: port 0 (load/store) over port 1 (debug/loader).
// Optional port-1 starvation guard is built when DRAM_ARB_STARVE_GUARD_EN is defined.
module dram_arb #(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 14,
    parameter int STARVE_MAX = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  p0_req_i,
    input  logic                  p0_we_i,
    input  logic [1:0]            p0_size_i,
    input  logic [ADDR_WIDTH-1:0] p0_addr_i,
    input  logic [XLEN-1:0]       p0_wdata_i,
    input  logic                  p1_req_i,
    input  logic                  p1_we_i,
    input  logic [1:0]            p1_size_i,
    input  logic [ADDR_WIDTH-1:0] p1_addr_i,
    input  logic [XLEN-1:0]       p1_wdata_i,
    output logic                  p0_gnt_o,
    output logic                  p1_gnt_o,
    output logic                  p0_rvalid_o,
    output logic                  p1_rvalid_o,
    output logic                  p0_err_o,
    output logic                  p1_err_o,
    output logic [XLEN-1:0]       rdata_o,
    output logic                  ram_en_o,
    output logic [3:0]            ram_we_o,
    output logic [ADDR_WIDTH-3:0] ram_addr_o,
    output logic [XLEN-1:0]       ram_wdata_o,
    input  logic [XLEN-1:0]       ram_rdata_i
);

    // Handshake: a port holds req and its attributes until gnt is seen in the same
    // cycle; a grant in cycle N yields exactly one rvalid pulse on that port in N+1.

    logic                  starve_force;
    logic                  gnt_any;
    logic                  sel_we;
    logic [1:0]            sel_size;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [XLEN-1:0]       sel_wdata;
    logic [1:0]            sel_off;
    logic                  sel_err;
    logic [3:0]            size_mask;

    logic                  rsp_valid_q;
    logic                  rsp_port_q;
    logic [1:0]            rsp_off_q;
    logic                  rsp_err_q;
    logic                  rsp_we_q;
    logic                  rsp_live;

`ifdef DRAM_ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_MAX + 1);
    logic [CW-1:0] starve_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_cnt_q <= '0;
        end else if (!p1_req_i || p1_gnt_o) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_q + 1'b1;
        end
    end

    assign starve_force = (starve_cnt_q == CW'(STARVE_MAX));
`else
    assign starve_force = 1'b0;
`endif

    // Reset masks grants so nothing reaches the RAM or the response register.
    assign p1_gnt_o = ~rst_i & p1_req_i & (~p0_req_i | starve_force);
    assign p0_gnt_o = ~rst_i & p0_req_i & ~p1_gnt_o;
    assign gnt_any  = p0_gnt_o | p1_gnt_o;

    assign sel_we    = p1_gnt_o ? p1_we_i    : p0_we_i;
    assign sel_size  = p1_gnt_o ? p1_size_i  : p0_size_i;
    assign sel_addr  = p1_gnt_o ? p1_addr_i  : p0_addr_i;
    assign sel_wdata = p1_gnt_o ? p1_wdata_i : p0_wdata_i;
    assign sel_off   = sel_addr[1:0];

    always_comb begin
        sel_err   = 1'b1;
        size_mask = 4'b0000;
        case (sel_size)
            2'b00: begin
                sel_err   = 1'b0;
                size_mask = 4'b0001;
            end
            2'b01: begin
                sel_err   = sel_off[0];
                size_mask = 4'b0011;
            end
            2'b10: begin
                sel_err   = |sel_off;
                size_mask = 4'b1111;
            end
            default: begin
                sel_err   = 1'b1;
                size_mask = 4'b0000;
            end
        endcase
    end

    always_comb begin
        ram_en_o    = 1'b0;
        ram_we_o    = 4'b0000;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        if (gnt_any && !sel_err) begin
            ram_en_o   = 1'b1;
            ram_addr_o = sel_addr[ADDR_WIDTH-1:2];
            if (sel_we) begin
                ram_we_o    = size_mask << sel_off;
                ram_wdata_o = sel_wdata << {sel_off, 3'b000};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_q <= 1'b0;
            rsp_port_q  <= 1'b0;
            rsp_off_q   <= 2'b00;
            rsp_err_q   <= 1'b0;
            rsp_we_q    <= 1'b0;
        end else begin
            rsp_valid_q <= gnt_any;
            rsp_port_q  <= p1_gnt_o;
            rsp_off_q   <= sel_off;
            rsp_err_q   <= sel_err;
            rsp_we_q    <= sel_we;
        end
    end

    // Upper bytes are left unmasked; the writeback extender trims them by size.
    assign rsp_live    = rsp_valid_q & ~rst_i;
    assign p0_rvalid_o = rsp_live & ~rsp_port_q;
    assign p1_rvalid_o = rsp_live & rsp_port_q;
    assign p0_err_o    = p0_rvalid_o & rsp_err_q;
    assign p1_err_o    = p1_rvalid_o & rsp_err_q;
    assign rdata_o     = (rsp_live && !rsp_err_q && !rsp_we_q) ?
                         (ram_rdata_i >> {rsp_off_q, 3'b000}) : '0;

endmodule

// File: tb/tb_dram_arb.sv
// Bench for dram_arb: byte-level reference memory and arbitration model feed an expected-response
// queue; a separate monitor checks each response. Honours DRAM_ARB_STARVE_GUARD_EN like the design.
module tb_dram_arb;

  localparam int STARVE_MAX = 8;

  logic        clk;
  logic        rst_i;
  logic        p0_req_i, p1_req_i;
  logic        p0_we_i, p1_we_i;
  logic [1:0]  p0_size_i, p1_size_i;
  logic [13:0] p0_addr_i, p1_addr_i;
  logic [31:0] p0_wdata_i, p1_wdata_i;
  logic        p0_gnt_o, p1_gnt_o;
  logic        p0_rvalid_o, p1_rvalid_o;
  logic        p0_err_o, p1_err_o;
  logic [31:0] rdata_o;
  logic        ram_en_o;
  logic [3:0]  ram_we_o;
  logic [11:0] ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic [31:0] ram_rdata;

  int n_checks;
  int n_fail;

  logic [33:0] exp_q[$];
  logic [7:0]  ref_mem [0:16383];
  logic [31:0] ram_mem [0:4095];
  logic [31:0] ram_merge;

  dram_arb #(.XLEN(32), .ADDR_WIDTH(14), .STARVE_MAX(STARVE_MAX)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .p0_req_i(p0_req_i), .p0_we_i(p0_we_i), .p0_size_i(p0_size_i),
    .p0_addr_i(p0_addr_i), .p0_wdata_i(p0_wdata_i),
    .p1_req_i(p1_req_i), .p1_we_i(p1_we_i), .p1_size_i(p1_size_i),
    .p1_addr_i(p1_addr_i), .p1_wdata_i(p1_wdata_i),
    .p0_gnt_o(p0_gnt_o), .p1_gnt_o(p1_gnt_o),
    .p0_rvalid_o(p0_rvalid_o), .p1_rvalid_o(p1_rvalid_o),
    .p0_err_o(p0_err_o), .p1_err_o(p1_err_o),
    .rdata_o(rdata_o),
    .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- RAM macro model (write-first across cycles) ----------------
  always_comb begin
    ram_merge = ram_mem[ram_addr_o];
    for (int b = 0; b < 4; b++)
      if (ram_we_o[b]) ram_merge[8*b +: 8] = ram_wdata_o[8*b +: 8];
  end

  always @(posedge clk) begin
    if (rst_i) begin
      for (int i = 0; i < 4096; i++) ram_mem[i] <= 32'h0;
      ram_rdata <= 32'h0;
    end else if (ram_en_o) begin
      ram_mem[ram_addr_o] <= ram_merge;
      ram_rdata <= ram_merge;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_port(input int port, input logic req, input logic we,
                            input logic [1:0] size, input logic [13:0] addr,
                            input logic [31:0] wdata);
    if (port == 0) begin
      p0_req_i = req; p0_we_i = we; p0_size_i = size; p0_addr_i = addr; p0_wdata_i = wdata;
    end else begin
      p1_req_i = req; p1_we_i = we; p1_size_i = size; p1_addr_i = addr; p1_wdata_i = wdata;
    end
  endtask

  task automatic rand_port(input int port);
    logic       req;
    logic [1:0] size;
    req  = ($urandom_range(0, 3) != 0);
    size = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
    drive_port(port, req, 1'($urandom_range(0, 1)), size,
               14'($urandom_range(0, 63)), $urandom);
  endtask

  // Drive one request, hold it until granted (bounded), then release.
  task automatic issue(input int port, input logic we, input logic [1:0] size,
                       input logic [13:0] addr, input logic [31:0] wdata);
    logic got;
    int   budget;
    drive_port(port, 1'b1, we, size, addr, wdata);
    got = 1'b0;
    budget = 0;
    while (!got && budget < 40) begin
      @(negedge clk);
      got = (port == 0) ? p0_gnt_o : p1_gnt_o;
      tick();
      budget++;
    end
    check("issue_grant", 32'(got), 32'd1);
    drive_port(port, 1'b0, 1'b0, 2'b00, 14'h0, 32'h0);
  endtask

  // ---------------- issue-side model: grants, RAM strobes, expected responses ----------------
  initial begin : issue_model
    int          wait_cnt;
    logic        fv, eg0, eg1, s_we, s_err;
    logic [1:0]  s_sz;
    int          s_addr, off, nb;
    logic [31:0] s_wd, e_data;
    logic [3:0]  e_we;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        check("rst_gnt", {30'h0, p1_gnt_o, p0_gnt_o}, 32'h0);
        check("rst_ram_en_we", {27'h0, ram_en_o, ram_we_o}, 32'h0);
        check("rst_ram_addr", 32'(ram_addr_o), 32'h0);
        check("rst_ram_wdata", ram_wdata_o, 32'h0);
        wait_cnt = 0;
        for (int i = 0; i < 16384; i++) ref_mem[i] = 8'h00;
      end else begin
`ifdef DRAM_ARB_STARVE_GUARD_EN
        fv = (wait_cnt == STARVE_MAX);
`else
        fv = 1'b0;
`endif
        eg1 = p1_req_i && (!p0_req_i || fv);
        eg0 = p0_req_i && !eg1;
        check("grant", {30'h0, p1_gnt_o, p0_gnt_o}, {30'h0, eg1, eg0});
        if (eg0 || eg1) begin
          s_we   = eg1 ? p1_we_i : p0_we_i;
          s_sz   = eg1 ? p1_size_i : p0_size_i;
          s_addr = eg1 ? int'(p1_addr_i) : int'(p0_addr_i);
          s_wd   = eg1 ? p1_wdata_i : p0_wdata_i;
          off    = s_addr % 4;
          nb     = (s_sz == 2'b00) ? 1 : (s_sz == 2'b01) ? 2 : (s_sz == 2'b10) ? 4 : 0;
          s_err  = (nb == 0) || ((s_addr % nb) != 0);
          if (s_err) begin
            check("err_ram_en", 32'(ram_en_o), 32'h0);
            check("err_ram_we", 32'(ram_we_o), 32'h0);
            exp_q.push_back({eg1, 1'b1, 32'h0});
          end else begin
            check("ram_en", 32'(ram_en_o), 32'h1);
            check("ram_addr", 32'(ram_addr_o), 32'(s_addr / 4));
            e_we = 4'h0;
            for (int i = 0; i < 4; i++) e_we[i] = s_we && (i >= off) && (i < off + nb);
            check("ram_we", 32'(ram_we_o), 32'(e_we));
            if (s_we) begin
              e_data = s_wd << (8 * off);
              check("ram_wdata", ram_wdata_o, e_data);
              for (int i = 0; i < nb; i++) ref_mem[s_addr + i] = s_wd[8*i +: 8];
              exp_q.push_back({eg1, 1'b0, 32'h0});
            end else begin
              e_data = 32'h0;
              for (int i = 0; i + off < 4; i++) e_data[8*i +: 8] = ref_mem[s_addr + i];
              exp_q.push_back({eg1, 1'b0, e_data});
            end
          end
        end else begin
          check("idle_ram_en_we", {27'h0, ram_en_o, ram_we_o}, 32'h0);
          check("idle_ram_addr", 32'(ram_addr_o), 32'h0);
          check("idle_ram_wdata", ram_wdata_o, 32'h0);
        end
        wait_cnt = (!p1_req_i || eg1) ? 0 : wait_cnt + 1;
      end
    end
  end

  // ---------------- response monitor ----------------
  initial begin : rsp_monitor
    logic [33:0] e;
    forever begin
      @(posedge clk);
      #3;
      if (rst_i) begin
        check("rst_rsp", {28'h0, p1_rvalid_o, p0_rvalid_o, p1_err_o, p0_err_o}, 32'h0);
        check("rst_rdata", rdata_o, 32'h0);
        exp_q.delete();
      end else if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rsp_rvalid", {30'h0, p1_rvalid_o, p0_rvalid_o}, e[33] ? 32'h2 : 32'h1);
        check("rsp_err", {30'h0, p1_err_o, p0_err_o},
              e[32] ? (e[33] ? 32'h2 : 32'h1) : 32'h0);
        check("rsp_rdata", rdata_o, e[31:0]);
      end else begin
        check("rvalid_without_grant", {30'h0, p1_rvalid_o, p0_rvalid_o}, 32'h0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stimulus
    int   first_p1, p1_count;
    logic g0, g1;
    n_checks = 0;
    n_fail   = 0;
    rst_i    = 1'b1;
    drive_port(0, 1'b0, 1'b0, 2'b00, 14'h0, 32'h0);
    drive_port(1, 1'b0, 1'b0, 2'b00, 14'h0, 32'h0);
    repeat (3) tick();
    rst_i = 1'b0;
    tick();

    // word store/load, byte store/load, misaligned half
    issue(0, 1'b1, 2'b10, 14'h0010, 32'hDEADBEEF);
    issue(0, 1'b0, 2'b10, 14'h0010, 32'h0);
    issue(0, 1'b1, 2'b00, 14'h0013, 32'h000000A5);
    issue(0, 1'b0, 2'b00, 14'h0013, 32'h0);
    issue(0, 1'b0, 2'b01, 14'h0011, 32'h0);
    tick();

    // both ports requesting continuously
    first_p1 = 0;
    p1_count = 0;
    drive_port(0, 1'b1, 1'b0, 2'b10, 14'h0020, 32'h0);
    drive_port(1, 1'b1, 1'b0, 2'b10, 14'h0024, 32'h0);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (p1_gnt_o) begin
        p1_count++;
        if (first_p1 == 0) first_p1 = c;
      end
      tick();
    end
    drive_port(0, 1'b0, 1'b0, 2'b00, 14'h0, 32'h0);
    drive_port(1, 1'b0, 1'b0, 2'b00, 14'h0, 32'h0);
`ifdef DRAM_ARB_STARVE_GUARD_EN
    check("starve_first_p1_gnt_cycle", 32'(first_p1), 32'd9);
`else
    check("starve_p1_gnt_count", 32'(p1_count), 32'd0);
`endif
    tick();

    // reset in the cycle a port 1 load would be granted
    drive_port(1, 1'b1, 1'b0, 2'b10, 14'h0004, 32'h0);
    rst_i = 1'b1;
    @(negedge clk);
    check("rst_p1_gnt_masked", 32'(p1_gnt_o), 32'h0);
    tick();
    rst_i = 1'b0;
    drive_port(1, 1'b0, 1'b0, 2'b00, 14'h0, 32'h0);
    @(negedge clk);
    check("rst_release_p1_rvalid", 32'(p1_rvalid_o), 32'h0);
    tick();

    // reset while a port 0 response is pending
    issue(0, 1'b0, 2'b10, 14'h0010, 32'h0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    @(negedge clk);
    check("drop_p0_rvalid", 32'(p0_rvalid_o), 32'h0);
    tick();

    // alternating port word loads, no cross-routing
    issue(0, 1'b1, 2'b10, 14'h0000, 32'h11111111);
    issue(1, 1'b1, 2'b10, 14'h0004, 32'h22222222);
    issue(0, 1'b0, 2'b10, 14'h0000, 32'h0);
    issue(1, 1'b0, 2'b10, 14'h0004, 32'h0);
    issue(0, 1'b0, 2'b10, 14'h0004, 32'h0);
    issue(1, 1'b0, 2'b10, 14'h0000, 32'h0);
    tick();

    // randomized traffic on both ports
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      g0 = p0_gnt_o;
      g1 = p1_gnt_o;
      tick();
      if (!p0_req_i || g0) rand_port(0);
      if (!p1_req_i || g1) rand_port(1);
    end
    drive_port(0, 1'b0, 1'b0, 2'b00, 14'h0, 32'h0);
    drive_port(1, 1'b0, 1'b0, 2'b00, 14'h0, 32'h0);
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
